codec_cfg_seq: RTL and testbench

CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

---
 rtl/codec_cfg_seq.sv | 135 +++++++++++++
 tb/tb_codec_cfg_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_seq.sv
// Codec register configuration sequencer: walks a fixed 10-entry table and issues one
// I2C write frame per entry, with retries on NACK and a fixed idle gap between frames.
module codec_cfg_seq #(
    parameter logic [7:0]  DEV_ADDR   = 8'h34,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        i2c_done,
    input  logic        i2c_ack_err,
    output logic        i2c_start,
    output logic [23:0] i2c_frame,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  reg_idx
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [3:0]    LAST_IDX  = 4'd9;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [23:0]   frame_q, frame_d;

    // Table entry as {reg_addr[6:0], reg_data[8:0]}.
    function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
        logic [15:0] e;
        e = '0;
        case (idx)
            4'd0:    e = {7'h0F, 9'h000};
            4'd1:    e = {7'h00, 9'h017};
            4'd2:    e = {7'h01, 9'h017};
            4'd3:    e = {7'h02, 9'h079};
            4'd4:    e = {7'h03, 9'h079};
            4'd5:    e = {7'h04, 9'h012};
            4'd6:    e = {7'h05, 9'h000};
            4'd7:    e = {7'h06, 9'h000};
            4'd8:    e = {7'h07, 9'h002};
            4'd9:    e = {7'h09, 9'h001};
            default: e = '0;
        endcase
        return e;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            S_LOAD: begin
                frame_d = {DEV_ADDR, cfg_entry(idx_q)};
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_ack_err) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            retry_d = '0;
                            gap_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            // Counter reaching zero still spends one more cycle in GAP, giving GAP_CYCLES total.
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            gap_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
        end
    end

    assign i2c_start = (state_q == S_SEND);
    assign i2c_frame = frame_q;
    assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign cfg_done  = (state_q == S_DONE);
    assign cfg_err   = (state_q == S_ERROR);
    assign reg_idx   = idx_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Bench for codec_cfg_seq: scenario table, hand-written reset/restart sequences and
// randomized NACK plans checked against a frame-list reference model.
module tb_codec_cfg_seq;

    localparam int GAP  = 4;
    localparam int RMAX = 3;

    logic        clk;
    logic        reset;
    logic        go;
    logic        i2c_done;
    logic        i2c_ack_err;
    logic        i2c_start;
    logic [23:0] i2c_frame;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [3:0]  reg_idx;

    int checks   = 0;
    int failures = 0;

    int          nack_plan [10];
    logic [23:0] exp_frames[10];

    typedef struct {
        int   nack_entry;
        int   nack_cnt;
        int   lat;
        logic exp_done;
        logic exp_err;
        int   exp_idx;
        int   exp_starts;
    } vec_t;
    vec_t vecs[6];

    codec_cfg_seq #(
        .DEV_ADDR  (8'h34),
        .GAP_CYCLES(GAP),
        .RETRY_MAX (RMAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .i2c_done   (i2c_done),
        .i2c_ack_err(i2c_ack_err),
        .i2c_start  (i2c_start),
        .i2c_frame  (i2c_frame),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .reg_idx    (reg_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one go-triggered sequence with a responding I2C engine driven by nack_plan.
    // abort_at>0 stops right after that many start pulses (engine left pending).
    task automatic run_seq(input int lat, input bit noise, input int abort_at,
                           output int n_starts, output bit m_done, output bit m_err,
                           output int m_idx);
        logic [23:0] exp_q[$];
        bit          ack_q[$];
        logic [23:0] cur_frame;
        bit          cur_ack;
        int          cyc, cnt, last_done, exp_n, quiet;
        bit          started, prev_start, aborted;

        exp_q.delete();
        ack_q.delete();
        m_err = 1'b0;
        m_idx = 9;
        for (int e = 0; e < 10; e++) begin
            int att;
            att = (nack_plan[e] > RMAX) ? RMAX + 1 : nack_plan[e] + 1;
            for (int a = 0; a < att; a++) begin
                exp_q.push_back(exp_frames[e]);
                ack_q.push_back(a < nack_plan[e]);
            end
            if (nack_plan[e] > RMAX) begin
                m_err = 1'b1;
                m_idx = e;
                break;
            end
        end
        m_done = !m_err;
        exp_n  = exp_q.size();

        cyc = 0; cnt = 0; last_done = -1; n_starts = 0;
        started = 0; prev_start = 0; aborted = 0;
        cur_frame = '0; cur_ack = 0;
        go = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            go = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0;
            if (busy) started = 1;
            if (i2c_start) begin
                chk("start_width", {31'd0, prev_start}, 32'd0);
                n_starts++;
                if (exp_q.size() == 0) begin
                    chk("extra_start", 32'(n_starts), 32'(exp_n));
                    cur_ack = 1'b0;
                end else begin
                    chk("frame", {8'd0, i2c_frame}, {8'd0, exp_q.pop_front()});
                    cur_ack = ack_q.pop_front();
                end
                if (last_done >= 0) chk("done_to_start", 32'(cyc - last_done), 32'(GAP + 2));
                cur_frame = i2c_frame;
                cnt = lat;
                if (n_starts == abort_at) begin
                    aborted = 1;
                    break;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    chk("frame_hold", {8'd0, i2c_frame}, {8'd0, cur_frame});
                    i2c_done = 1'b1;
                    i2c_ack_err = cur_ack;
                    last_done = cyc;
                end
            end else if (noise && busy) begin
                go = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    i2c_done = 1'b1;
                    i2c_ack_err = 1'($urandom_range(0, 1));
                end
            end
            prev_start = i2c_start;
            if (started && !busy) break;
            if (cyc > 4000) begin
                checks++;
                failures++;
                $display("FAIL seq_timeout: busy=%0b after %0d cycles, limit 4000", busy, cyc);
                break;
            end
        end
        if (!aborted) begin
            chk("start_count", 32'(n_starts), 32'(exp_n));
            chk("model_done", {31'd0, cfg_done}, {31'd0, m_done});
            chk("model_err", {31'd0, cfg_err}, {31'd0, m_err});
            chk("model_idx", {28'd0, reg_idx}, 32'(m_idx));
            quiet = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (i2c_start) quiet++;
            end
            chk("quiet_after_end", 32'(quiet), 32'd0);
        end
    endtask

    initial begin
        int  ns, midx;
        bit  mdone, merr;
        int  bad;

        exp_frames = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                       24'h340812, 24'h340A00, 24'h340C00, 24'h340E02, 24'h341201};
        vecs[0] = '{-1, 0, 20, 1'b1, 1'b0, 9, 10};
        vecs[1] = '{ 3, 2, 20, 1'b1, 1'b0, 9, 12};
        vecs[2] = '{ 5, 9, 20, 1'b0, 1'b1, 5,  9};
        vecs[3] = '{ 9, 3,  5, 1'b1, 1'b0, 9, 13};
        vecs[4] = '{ 0, 4,  3, 1'b0, 1'b1, 0,  4};
        vecs[5] = '{ 9, 4,  1, 1'b0, 1'b1, 9, 13};

        reset = 1'b0; go = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", {31'd0, i2c_start}, 32'd0);
        chk("rst_frame", {8'd0, i2c_frame}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_idx", {28'd0, reg_idx}, 32'd0);
        reset = 1'b1;

        // Spurious done while idle.
        @(negedge clk);
        i2c_done = 1'b1; i2c_ack_err = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0; i2c_ack_err = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (i2c_start || busy || cfg_err || cfg_done) bad++;
            @(negedge clk);
        end
        chk("idle_spurious_done", 32'(bad), 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int e = 0; e < 10; e++) nack_plan[e] = 0;
            if (vecs[v].nack_entry >= 0) nack_plan[vecs[v].nack_entry] = vecs[v].nack_cnt;
            run_seq(vecs[v].lat, 1'b0, 0, ns, mdone, merr, midx);
            chk("tbl_starts", 32'(ns), 32'(vecs[v].exp_starts));
            chk("tbl_done", {31'd0, cfg_done}, {31'd0, vecs[v].exp_done});
            chk("tbl_err", {31'd0, cfg_err}, {31'd0, vecs[v].exp_err});
            chk("tbl_idx", {28'd0, reg_idx}, 32'(vecs[v].exp_idx));
            chk("tbl_busy", {31'd0, busy}, 32'd0);
        end

        // Reset while entry 4 is pending in WAIT, then a late done.
        for (int e = 0; e < 10; e++) nack_plan[e] = 0;
        run_seq(20, 1'b0, 5, ns, mdone, merr, midx);
        repeat (3) @(negedge clk);
        chk("pre_rst_idx", {28'd0, reg_idx}, 32'd4);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_frame", {8'd0, i2c_frame}, 32'd0);
        chk("mid_rst_idx", {28'd0, reg_idx}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        i2c_done = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (i2c_start || busy || cfg_done || cfg_err || reg_idx != 4'd0) bad++;
            @(negedge clk);
        end
        chk("late_done_ignored", 32'(bad), 32'd0);
        run_seq(7, 1'b0, 0, ns, mdone, merr, midx);
        chk("restart_starts", 32'(ns), 32'd10);

        // go held through reset release starts on the first edge.
        reset = 1'b0; go = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("go_thru_rst_busy", {31'd0, busy}, 32'd1);
        go = 1'b0;
        @(negedge clk);
        chk("go_thru_rst_start", {31'd0, i2c_start}, 32'd1);
        chk("go_thru_rst_frame", {8'd0, i2c_frame}, 32'h00341E00);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Randomized NACK plans with noise (go while busy, done outside WAIT).
        for (int r = 0; r < 20; r++) begin
            for (int e = 0; e < 10; e++)
                nack_plan[e] = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(0, 4));
            run_seq(int'($urandom_range(1, 8)), 1'b1, 0, ns, mdone, merr, midx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
